dmtd_meas_ctrl: RTL
===================

DMTD_MEAS_CTRL -- requirements
Module: dmtd_meas_ctrl

Interface
REQ-001 Parameter CNT_W, default 24: width of the period and high-time counters and of the result outputs.
REQ-002 Parameter AVG_LOG2, default 2: log2 of the number of beat periods averaged per measurement (N = 2^AVG_LOG2).
REQ-003 Parameter GLITCH_CYC, default 4: number of consecutive equal samples required before the filtered beat level changes.
REQ-004 Parameter TIMEOUT_CYC, default 2^20: per-period cycle limit; SHALL satisfy TIMEOUT_CYC < 2^CNT_W.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-007 start  input  1  one-cycle pulse that begins a measurement; ignored unless state is IDLE.
REQ-008 beat_in  input  1  XOR beat signal from the dual-mixer synchronizer output, already synchronous to clk.
REQ-009 result_ready  input  1  consumer accepts the result when high while result_valid is high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 result_valid  output  1  result fields are valid; held until accepted.
REQ-012 period_avg  output  CNT_W  averaged beat period in clk cycles.
REQ-013 high_avg  output  CNT_W  averaged beat high time in clk cycles.
REQ-014 timeout_err  output  1  measurement aborted because one period reached TIMEOUT_CYC.

Function
REQ-015 Glitch filter: filt changes to the value of beat_in only after beat_in has differed from filt for GLITCH_CYC consecutive cycles; any intervening sample equal to filt resets the run counter to 0.
REQ-016 A filtered rise (rise_f) is a cycle in which filt changes from 0 to 1. Both edges are delayed equally, so widths are preserved.
REQ-017 States: IDLE, SYNC, WAIT_RISE, MEASURE, HOLD.
REQ-018 IDLE: on start -> SYNC; clear the accumulators, the period index, timeout_err, and result_valid.
REQ-019 SYNC: wait until filt == 0 -> WAIT_RISE; this prevents a partial first period when the beat is high at start.
REQ-020 WAIT_RISE: on rise_f -> MEASURE; clear the period and high counters to 1 and 0 respectively in that cycle.
REQ-021 MEASURE: the period counter increments every cycle; the high counter increments in every cycle where filt == 1.
REQ-022 MEASURE, on rise_f: add the period count to sum_p and the high count to sum_h; increment the period index; restart the counters as in REQ-020.
REQ-023 When the period index reaches N, the next state is HOLD. In the cycle after the N-th completing rise_f: result_valid = 1, period_avg = sum_p >> AVG_LOG2, high_avg = sum_h >> AVG_LOG2 (truncating).
REQ-024 Accumulators SHALL be CNT_W+AVG_LOG2 bits wide; no overflow is possible given REQ-004.
REQ-025 Timeout: in SYNC, WAIT_RISE or MEASURE, if the cycles spent in the current wait or period reach TIMEOUT_CYC -> HOLD, with result_valid = 1, timeout_err = 1, and period_avg = high_avg = 0.
REQ-026 HOLD: outputs are stable. On result_valid && result_ready -> IDLE, and result_valid drops the next cycle; timeout_err and the averages keep their values until the next start.
REQ-027 start asserted in IDLE in the same cycle as a stale accept SHALL be honoured (accept takes effect first).
REQ-028 start pulses outside IDLE are ignored; there is no restart mid-measurement.
REQ-029 rise_f during SYNC is ignored; rise_f in the same cycle as a timeout expiry: the timeout wins.

Reset
REQ-030 While rst == 0 at a clock edge: state = IDLE; filt, the run counter, the counters, the accumulators, and the period index = 0.
REQ-031 While rst == 0 at a clock edge: busy = 0, result_valid = 0, timeout_err = 0, period_avg = high_avg = 0.
REQ-032 Reset asserted mid-measurement SHALL abort the measurement with no result produced; operation resumes only on a new start after rst returns to 1.

Verification
REQ-033 Defaults (AVG_LOG2 = 2, GLITCH_CYC = 4); beat 10 high / 30 low, continuous; start -> result_valid one cycle after the 5th rise_f; period_avg = 40, high_avg = 10, timeout_err = 0.
REQ-034 Periods 40, 41, 40, 42 with high 10, 11, 10, 12 -> sum_p = 163, so period_avg = 40; sum_h = 43, so high_avg = 10.
REQ-035 2-cycle glitches injected in the low phase of REQ-033 -> results identical to REQ-033; 4-cycle pulses -> counted as extra periods.
REQ-036 beat_in held at 0 after start, with TIMEOUT_CYC = 1000 -> result_valid and timeout_err both high 1000 cycles after WAIT_RISE entry; averages = 0.
REQ-037 result_ready held low for 50 cycles in HOLD -> outputs stable throughout; accept -> IDLE, and busy drops next cycle; a start pulse during MEASURE has no effect.
REQ-038 rst = 0 for 1 cycle during MEASURE -> all outputs 0 next cycle; no result_valid until a new start completes.

Source files
------------

// File: rtl/dmtd_meas_ctrl.sv
// DMTD beat-period measurement controller.
// Debounces the mixer beat, then averages 2^AVG_LOG2 beat periods and high
// times. A per-period timeout guards against a dead beat. The result is held
// on a valid/ready handshake until the consumer accepts it.
module dmtd_meas_ctrl #(
  parameter int CNT_W       = 24,
  parameter int AVG_LOG2    = 2,
  parameter int GLITCH_CYC  = 4,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             beat_in,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] period_avg,
  output logic [CNT_W-1:0] high_avg,
  output logic             timeout_err
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int RUN_W = $clog2(GLITCH_CYC + 1);
  localparam int IDX_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(GLITCH_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic               filt_q, filt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [ACC_W-1:0]   sum_p_q, sum_p_d;
  logic [ACC_W-1:0]   sum_h_q, sum_h_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   pavg_q, pavg_d;
  logic [CNT_W-1:0]   havg_q, havg_d;

  logic               rise_f;
  logic               timed_out;
  logic [ACC_W-1:0]   sum_p_next;
  logic [ACC_W-1:0]   sum_h_next;

  // Glitch filter: follow beat_in only after GLITCH_CYC consecutive differing samples.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    filt_d = filt_q;
    run_d  = '0;
    if (beat_in != filt_q) begin
      if (run_q == RUN_LAST) filt_d = beat_in;
      else                   run_d  = run_q + RUN_W'(1);
    end
  end

  // The filtered rise is the cycle in which filt is about to go from 0 to 1.
  assign rise_f     = ~filt_q & filt_d;
  // period_q doubles as the age counter of the current wait or period.
  assign timed_out  = (period_q >= TIMEOUT_LIM);
  assign sum_p_next = sum_p_q + ACC_W'(period_q);
  assign sum_h_next = sum_h_q + ACC_W'(high_q);

  // Measurement sequencing: next state, counters, accumulators and result fields.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    sum_p_d  = sum_p_q;
    sum_h_d  = sum_h_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    err_d    = err_q;
    pavg_d   = pavg_q;
    havg_d   = havg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SYNC;
          period_d = ONE;
          high_d   = '0;
          sum_p_d  = '0;
          sum_h_d  = '0;
          idx_d    = '0;
          valid_d  = 1'b0;
          err_d    = 1'b0;
          pavg_d   = '0;
          havg_d   = '0;
        end
      end
      S_SYNC, S_WAIT_RISE, S_MEASURE: begin
        if (timed_out) begin
          // Expiry outranks any rise seen in the same cycle.
          state_d = S_HOLD;
          valid_d = 1'b1;
          err_d   = 1'b1;
          pavg_d  = '0;
          havg_d  = '0;
        end else if (state_q == S_SYNC) begin
          // Wait for a low beat so the first measured period is complete.
          if (!filt_q) begin
            state_d  = S_WAIT_RISE;
            period_d = ONE;
          end else begin
            period_d = period_q + ONE;
          end
        end else if (rise_f) begin
          state_d  = S_MEASURE;
          period_d = ONE;
          high_d   = '0;
          if (state_q == S_MEASURE) begin
            sum_p_d = sum_p_next;
            sum_h_d = sum_h_next;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d = S_HOLD;
              valid_d = 1'b1;
              pavg_d  = CNT_W'(sum_p_next >> AVG_LOG2);
              havg_d  = CNT_W'(sum_h_next >> AVG_LOG2);
            end
          end
        end else begin
          period_d = period_q + ONE;
          if (state_q == S_MEASURE) high_d = high_q + CNT_W'(filt_q);
        end
      end
      S_HOLD: begin
        if (valid_q && result_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q  <= S_IDLE;
      filt_q   <= 1'b0;
      run_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      sum_p_q  <= '0;
      sum_h_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      pavg_q   <= '0;
      havg_q   <= '0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      run_q    <= run_d;
      period_q <= period_d;
      high_q   <= high_d;
      sum_p_q  <= sum_p_d;
      sum_h_q  <= sum_h_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      pavg_q   <= pavg_d;
      havg_q   <= havg_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = valid_q;
  assign timeout_err  = err_q;
  assign period_avg   = pavg_q;
  assign high_avg     = havg_q;

endmodule
